// File: rtl/vga_scan_out.sv
// rtl/vga_scan_out.sv - VGA scan-out that centres the frame-store image in the active area
module vga_scan_out #(
  parameter int          H_ACTIVE     = 640,
  parameter int          H_FP         = 16,
  parameter int          H_SYNC       = 96,
  parameter int          H_BP         = 48,
  parameter int          V_ACTIVE     = 480,
  parameter int          V_FP         = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BP         = 33,
  parameter int          IMG_W        = 250,
  parameter int          IMG_H        = 250,
  parameter int          X_OFF        = 195,
  parameter int          Y_OFF        = 115,
  parameter int          RD_LAT       = 2,
  parameter logic [23:0] NO_IMG_COLOR = 24'h404040,
  parameter logic [23:0] BORDER_COLOR = 24'h000000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FRAME_READY,
  output logic        RD_EN,
  output logic [15:0] RD_ADDRESS,
  input  logic [23:0] RD_DATA,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic        FRAME_TICK
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int D       = RD_LAT + 1;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] WX_START  = HW'(X_OFF);
  localparam logic [HW-1:0] WX_END    = HW'(X_OFF + IMG_W);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] WY_START  = VW'(Y_OFF);
  localparam logic [VW-1:0] WY_END    = VW'(Y_OFF + IMG_H);
  localparam logic [15:0]   ADDR_LAST = 16'(IMG_W * IMG_H - 1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          frame_end;
  logic          frame_start;
  logic          hs_raw;
  logic          vs_raw;
  logic          act_raw;
  logic          win_raw;
  logic          armed_pend;
  logic          armed;
  logic [D-1:0]  hs_d;
  logic [D-1:0]  vs_d;
  logic [D-1:0]  act_d;
  logic [D-1:0]  win_d;
  logic [D-1:0]  arm_d;
  logic [23:0]   pix;

  assign frame_end   = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign frame_start = (h_cnt == '0) && (v_cnt == '0);
  assign hs_raw      = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vs_raw      = !((v_cnt >= VS_START) && (v_cnt < VS_END));
  assign act_raw     = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign win_raw     = (h_cnt >= WX_START) && (h_cnt < WX_END) &&
                       (v_cnt >= WY_START) && (v_cnt < WY_END);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Display only switches on at a frame boundary; a request landing on the boundary still counts.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      armed_pend <= 1'b0;
      armed      <= 1'b0;
    end else begin
      if (FRAME_READY)
        armed_pend <= 1'b1;
      if (frame_end)
        armed <= armed | armed_pend | FRAME_READY;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      RD_EN      <= 1'b0;
      RD_ADDRESS <= '0;
    end else begin
      RD_EN <= win_raw && armed;
      if (frame_start)
        RD_ADDRESS <= '0;
      else if (RD_EN)
        RD_ADDRESS <= (RD_ADDRESS == ADDR_LAST) ? '0 : RD_ADDRESS + 16'd1;
    end
  end

  // Syncs reset to their idle level so the pins never glitch active while the pipe refills.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hs_d  <= '1;
      vs_d  <= '1;
      act_d <= '0;
      win_d <= '0;
      arm_d <= '0;
    end else begin
      hs_d  <= {hs_d[D-2:0], hs_raw};
      vs_d  <= {vs_d[D-2:0], vs_raw};
      act_d <= {act_d[D-2:0], act_raw};
      win_d <= {win_d[D-2:0], win_raw};
      arm_d <= {arm_d[D-2:0], armed};
    end
  end

  always_comb begin
    pix = 24'h000000;
    if (!act_d[D-1])
      pix = 24'h000000;
    else if (!win_d[D-1])
      pix = BORDER_COLOR;
    else if (!arm_d[D-1])
      pix = NO_IMG_COLOR;
    else
      pix = RD_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      FRAME_TICK  <= 1'b0;
    end else begin
      {VGA_R, VGA_G, VGA_B} <= pix;
      VGA_HS      <= hs_d[D-1];
      VGA_VS      <= vs_d[D-1];
      VGA_BLANK_N <= act_d[D-1];
      FRAME_TICK  <= frame_end;
    end
  end

  assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_scan_out.sv
// tb/tb_vga_scan_out.sv - randomized model-checked bench for vga_scan_out
module tb_vga_scan_out;

  localparam int S_HA = 40, S_HF = 4, S_HS = 6, S_HB = 6;
  localparam int S_VA = 30, S_VF = 3, S_VS = 2, S_VB = 4;
  localparam int S_X = 12, S_Y = 9, S_W = 16, S_H = 12;
  localparam int S_HT  = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT  = S_VA + S_VF + S_VS + S_VB;
  localparam int S_F   = S_HT * S_VT;
  localparam int S_PIX = S_W * S_H;
  localparam int F_F   = 800 * 525;
  localparam longint NOARM = 64'h3fff_ffff_ffff_ffff;

  typedef struct packed {
    int ha; int hf; int hs; int hb; int va; int vf; int vs; int vb;
    int x; int y; int w; int h;
  } geo_t;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        bl;
    logic [23:0] rgb;
  } pins_t;

  localparam geo_t GS = '{S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, S_X, S_Y, S_W, S_H};
  localparam geo_t GF = '{640, 16, 96, 48, 480, 10, 2, 33, 195, 115, 250, 250};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        fr;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [23:0] rd_data;
  logic [7:0]  vr, vg, vb;
  logic        hs, vs, blank_n, sync_n, tick;

  logic        f_fr;
  logic        f_rd_en;
  logic [15:0] f_rd_addr;
  logic [23:0] f_rd_data;
  logic [7:0]  f_r, f_g, f_b;
  logic        f_hs, f_vs, f_blank_n, f_sync_n, f_tick;

  vga_scan_out #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .IMG_W(S_W), .IMG_H(S_H), .X_OFF(S_X), .Y_OFF(S_Y), .RD_LAT(2)
  ) dut (
    .CLK(clk), .RESET(reset), .FRAME_READY(fr), .RD_EN(rd_en), .RD_ADDRESS(rd_addr),
    .RD_DATA(rd_data), .VGA_R(vr), .VGA_G(vg), .VGA_B(vb), .VGA_HS(hs), .VGA_VS(vs),
    .VGA_BLANK_N(blank_n), .VGA_SYNC_N(sync_n), .FRAME_TICK(tick)
  );

  vga_scan_out dut_full (
    .CLK(clk), .RESET(reset), .FRAME_READY(f_fr), .RD_EN(f_rd_en), .RD_ADDRESS(f_rd_addr),
    .RD_DATA(f_rd_data), .VGA_R(f_r), .VGA_G(f_g), .VGA_B(f_b), .VGA_HS(f_hs), .VGA_VS(f_vs),
    .VGA_BLANK_N(f_blank_n), .VGA_SYNC_N(f_sync_n), .FRAME_TICK(f_tick)
  );

  // Frame stores with a two-cycle read latency.
  logic [15:0] s_a1 = '0, s_a2 = '0, f_a1 = '0, f_a2 = '0;
  always @(posedge clk) begin
    s_a1 <= rd_addr;
    s_a2 <= s_a1;
    f_a1 <= f_rd_addr;
    f_a2 <= f_a1;
  end
  assign rd_data   = {s_a2[7:0], s_a2[15:8], 8'h5A};
  assign f_rd_data = {f_a2[7:0], f_a2[15:8], 8'h5A};

  int     errors, checks;
  longint cyc, arm_from;
  longint fr_q[$];
  int     mm_pin, mm_rd, mm_tick, mm_full;
  string  msg_pin, msg_rd, msg_full;
  int     hs_lo, vs_lo, bl_hi, tick_cnt, rd_total;
  int     f_hs_lo, f_vs_lo, f_bl_hi;
  int     rd_cnt[16];

  function automatic void locate(input geo_t g, input longint s, output int h, output int v);
    longint ht, f, p;
    ht = longint'(g.ha + g.hf + g.hs + g.hb);
    f  = ht * longint'(g.va + g.vf + g.vs + g.vb);
    p  = s % f;
    if (p < 0) p = p + f;
    h = int'(p % ht);
    v = int'(p / ht);
  endfunction

  function automatic bit in_win(input geo_t g, input int h, input int v);
    return (h >= g.x) && (h < g.x + g.w) && (v >= g.y) && (v < g.y + g.h);
  endfunction

  function automatic logic [23:0] store_word(input int a);
    logic [15:0] w;
    w = 16'(a);
    return {w[7:0], w[15:8], 8'h5A};
  endfunction

  // Pin values for the counter position s cycles after reset release.
  function automatic pins_t pins_exp(input geo_t g, input longint s, input longint arm_at);
    pins_t e;
    int h, v;
    locate(g, s, h, v);
    e.hs = ((h >= g.ha + g.hf) && (h < g.ha + g.hf + g.hs)) ? 1'b0 : 1'b1;
    e.vs = ((v >= g.va + g.vf) && (v < g.va + g.vf + g.vs)) ? 1'b0 : 1'b1;
    e.bl = ((h < g.ha) && (v < g.va)) ? 1'b1 : 1'b0;
    if (e.bl == 1'b0)        e.rgb = 24'h000000;
    else if (!in_win(g, h, v)) e.rgb = 24'h000000;
    else if (s < arm_at)     e.rgb = 24'h404040;
    else                     e.rgb = store_word((v - g.y) * g.w + (h - g.x));
    return e;
  endfunction

  task automatic clear_stats();
    mm_pin = 0; mm_rd = 0; mm_tick = 0; mm_full = 0;
    msg_pin = ""; msg_rd = ""; msg_full = "";
    hs_lo = 0; vs_lo = 0; bl_hi = 0; tick_cnt = 0; rd_total = 0;
    f_hs_lo = 0; f_vs_lo = 0; f_bl_hi = 0;
    for (int k = 0; k < 16; k++) rd_cnt[k] = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      fr = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    reset = 1'b0;
    fr = 1'b0;
    cyc = 0;
    arm_from = NOARM;
    fr_q.delete();
  endtask

  task automatic run(input int n);
    pins_t  e, a;
    int     h, v;
    bit     en;
    longint s, cand;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cyc = cyc + 1;
      fr = 1'b0;
      if (fr_q.size() != 0 && fr_q[0] == cyc) begin
        void'(fr_q.pop_front());
        fr = 1'b1;
        cand = (cyc / S_F + 1) * S_F;
        if (cand < arm_from) arm_from = cand;
      end
      e = pins_exp(GS, cyc - 4, arm_from);
      a.hs = hs; a.vs = vs; a.bl = blank_n; a.rgb = {vr, vg, vb};
      if (a !== e || sync_n !== 1'b0) begin
        mm_pin++;
        if (msg_pin == "") msg_pin = $sformatf("cyc %0d got %h want %h", cyc, a, e);
      end
      s = cyc - 1;
      locate(GS, s, h, v);
      en = in_win(GS, h, v) && (s >= arm_from);
      if (rd_en !== en || (en && rd_addr !== 16'((v - S_Y) * S_W + (h - S_X)))) begin
        mm_rd++;
        if (msg_rd == "") msg_rd = $sformatf("cyc %0d got en=%b addr=%0d want en=%b at h=%0d v=%0d", cyc, rd_en, rd_addr, en, h, v);
      end
      if (tick !== ((cyc % S_F) == 0)) mm_tick++;
      if (hs === 1'b0) hs_lo++;
      if (vs === 1'b0) vs_lo++;
      if (blank_n === 1'b1) bl_hi++;
      if (tick === 1'b1) tick_cnt++;
      if (rd_en === 1'b1) begin
        rd_total++;
        if ((cyc - 1) / S_F < 16) rd_cnt[int'((cyc - 1) / S_F)]++;
      end
      e = pins_exp(GF, cyc - 4, NOARM);
      a.hs = f_hs; a.vs = f_vs; a.bl = f_blank_n; a.rgb = {f_r, f_g, f_b};
      if (a !== e || f_rd_en !== 1'b0 || f_sync_n !== 1'b0 || f_tick !== ((cyc % F_F) == 0)) begin
        mm_full++;
        if (msg_full == "") msg_full = $sformatf("cyc %0d got %h want %h rd_en=%b tick=%b", cyc, a, e, f_rd_en, f_tick);
      end
      if (f_hs === 1'b0) f_hs_lo++;
      if (f_vs === 1'b0) f_vs_lo++;
      if (f_blank_n === 1'b1) f_bl_hi++;
    end
  endtask

  task automatic test_reset();
    do_reset(3);
    checks++;
    if ({rd_en, rd_addr} !== 17'h0) begin
      errors++; $display("FAIL reset_read: got en=%b addr=%0d, required 0/0", rd_en, rd_addr);
    end
    checks++;
    if ({hs, vs, blank_n, sync_n, tick, vr, vg, vb} !== {5'b11000, 24'h0}) begin
      errors++; $display("FAIL reset_video: got hs=%b vs=%b bl=%b sy=%b tk=%b rgb=%h, required 1 1 0 0 0 000000",
                         hs, vs, blank_n, sync_n, tick, {vr, vg, vb});
    end
    clear_stats();
    run(2 * S_F + 3);
    checks++;
    if (mm_pin !== 0) begin errors++; $display("FAIL noimg_pins: %0d bad cycles, required 0 (%s)", mm_pin, msg_pin); end
    checks++;
    if (rd_total !== 0) begin errors++; $display("FAIL noimg_rd_en: got %0d reads, required 0", rd_total); end
    checks++;
    if (hs_lo !== 2 * S_VT * S_HS) begin errors++; $display("FAIL small_hs_low: got %0d, required %0d", hs_lo, 2 * S_VT * S_HS); end
    checks++;
    if (vs_lo !== 2 * S_VS * S_HT) begin errors++; $display("FAIL small_vs_low: got %0d, required %0d", vs_lo, 2 * S_VS * S_HT); end
    checks++;
    if (bl_hi !== 2 * S_VA * S_HA) begin errors++; $display("FAIL small_blank_hi: got %0d, required %0d", bl_hi, 2 * S_VA * S_HA); end
    checks++;
    if (tick_cnt !== 2 || mm_tick !== 0) begin
      errors++; $display("FAIL frame_tick: got %0d ticks (%0d misplaced), required 2 (0)", tick_cnt, mm_tick);
    end
  endtask

  task automatic test_full_timing();
    do_reset(1);
    clear_stats();
    run(16003);
    checks++;
    if (mm_full !== 0) begin errors++; $display("FAIL full_model: %0d bad cycles, required 0 (%s)", mm_full, msg_full); end
    checks++;
    if (f_hs_lo !== 20 * 96) begin errors++; $display("FAIL full_hs_low: got %0d, required %0d", f_hs_lo, 20 * 96); end
    checks++;
    if (f_bl_hi !== 20 * 640) begin errors++; $display("FAIL full_blank_hi: got %0d, required %0d", f_bl_hi, 20 * 640); end
    checks++;
    if (f_vs_lo !== 0) begin errors++; $display("FAIL full_vs_low: got %0d, required 0", f_vs_lo); end
  endtask

  task automatic test_arm_mid_frame();
    do_reset(1);
    clear_stats();
    fr_q.push_back(longint'(15 * S_HT + $urandom_range(0, S_HT - 1)));
    run(2 * S_F + 3);
    checks++;
    if (mm_pin !== 0) begin errors++; $display("FAIL arm_pins: %0d bad cycles, required 0 (%s)", mm_pin, msg_pin); end
    checks++;
    if (mm_rd !== 0) begin errors++; $display("FAIL arm_reads: %0d bad cycles, required 0 (%s)", mm_rd, msg_rd); end
    checks++;
    if (rd_cnt[0] !== 0 || rd_cnt[1] !== S_PIX) begin
      errors++; $display("FAIL arm_read_count: got %0d/%0d, required 0/%0d", rd_cnt[0], rd_cnt[1], S_PIX);
    end
  endtask

  task automatic test_boundary();
    do_reset(1);
    clear_stats();
    fr_q.push_back(longint'(S_F - 1));
    run(2 * S_F + 3);
    checks++;
    if (rd_cnt[0] !== 0 || rd_cnt[1] !== S_PIX) begin
      errors++; $display("FAIL edge_ready_count: got %0d/%0d, required 0/%0d", rd_cnt[0], rd_cnt[1], S_PIX);
    end
    checks++;
    if (mm_pin !== 0 || mm_rd !== 0) begin
      errors++; $display("FAIL edge_ready_model: got %0d/%0d bad, required 0 (%s %s)", mm_pin, mm_rd, msg_pin, msg_rd);
    end
    do_reset(1);
    clear_stats();
    fr_q.push_back(longint'(S_F));
    run(3 * S_F + 3);
    checks++;
    if (rd_cnt[1] !== 0 || rd_cnt[2] !== S_PIX) begin
      errors++; $display("FAIL late_ready_count: got %0d/%0d, required 0/%0d", rd_cnt[1], rd_cnt[2], S_PIX);
    end
    checks++;
    if (mm_pin !== 0 || mm_rd !== 0) begin
      errors++; $display("FAIL late_ready_model: got %0d/%0d bad, required 0 (%s %s)", mm_pin, mm_rd, msg_pin, msg_rd);
    end
  endtask

  task automatic test_reset_mid();
    longint target;
    target = longint'(15 * S_HT + 20);
    for (int k = 0; k < S_F && (cyc % S_F) != target; k++) run(1);
    checks++;
    if ((cyc % S_F) !== target) begin errors++; $display("FAIL mid_reset_reach: got pos %0d, required %0d", cyc % S_F, target); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    cyc = 0;
    arm_from = NOARM;
    checks++;
    if ({rd_en, rd_addr} !== 17'h0) begin
      errors++; $display("FAIL mid_reset_read: got en=%b addr=%0d, required 0/0", rd_en, rd_addr);
    end
    checks++;
    if ({hs, vs, blank_n, tick, vr, vg, vb} !== {4'b1100, 24'h0}) begin
      errors++; $display("FAIL mid_reset_video: got hs=%b vs=%b bl=%b tk=%b rgb=%h, required 1 1 0 0 000000",
                         hs, vs, blank_n, tick, {vr, vg, vb});
    end
    clear_stats();
    run(2 * S_F + 3);
    checks++;
    if (rd_total !== 0 || mm_pin !== 0) begin
      errors++; $display("FAIL mid_reset_disarm: got %0d reads %0d bad pins, required 0/0 (%s)", rd_total, mm_pin, msg_pin);
    end
    checks++;
    if (tick_cnt !== 2 || mm_full !== 0) begin
      errors++; $display("FAIL mid_reset_restart: got %0d ticks %0d full bad, required 2/0 (%s)", tick_cnt, mm_full, msg_full);
    end
  endtask

  task automatic test_back_to_back();
    longint first, p;
    int     af;
    do_reset(1);
    clear_stats();
    first = longint'($urandom_range(1, 2 * S_F));
    fr_q.push_back(first);
    p = first;
    for (int k = 0; k < 3; k++) begin
      p = p + longint'($urandom_range(1, S_F));
      fr_q.push_back(p);
    end
    af = int'(first / S_F) + 1;
    run(5 * S_F + 3);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rd_cnt[k] !== ((k >= af) ? S_PIX : 0)) begin
        errors++; $display("FAIL b2b_frame%0d_reads: got %0d, required %0d", k, rd_cnt[k], (k >= af) ? S_PIX : 0);
      end
    end
    checks++;
    if (mm_pin !== 0 || mm_rd !== 0 || mm_tick !== 0) begin
      errors++; $display("FAIL b2b_model: got %0d/%0d/%0d bad, required 0 (%s %s)", mm_pin, mm_rd, mm_tick, msg_pin, msg_rd);
    end
  endtask

  initial begin
    reset = 1'b1;
    fr = 1'b0;
    f_fr = 1'b0;
    errors = 0;
    checks = 0;
    cyc = 0;
    arm_from = NOARM;
    test_reset();
    test_full_timing();
    test_arm_mid_frame();
    test_boundary();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
